norestore_seq_divider: RTL
==========================

Name: norestore_seq_divider

Overview:
- Iterative non-restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor, giving a 2*WIDTH-bit quotient and a WIDTH-bit remainder.
- Successor to the fixed single-step cell divider. Adds:
  - valid/ready handshakes on input and output;
  - configurable iterations per clock (STEPS);
  - per-operation signed/unsigned mode;
  - divide-by-zero reporting.
- Sits between an operand-issuing controller and a result consumer in the arithmetic datapath.

Parameters:
- WIDTH, 4, divisor/remainder width; dividend/quotient are 2*WIDTH. Legal range is WIDTH >= 2.
- STEPS, 1, non-restoring iterations per clock. Must divide 2*WIDTH; elaboration fails otherwise.

Ports:
- clk  input  1  clock.
- rst  input  1  reset. One clock; reset is asynchronous and active-high.
- in_valid  input  1  operands presented.
- in_ready  output  1  block can accept operands.
- signed_mode  input  1  1 = two's-complement operands/results; sampled with operands.
- dividend  input  2*WIDTH  numerator.
- divisor  input  WIDTH  denominator.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- dout  output  2*WIDTH  quotient.
- remainder  output  WIDTH  remainder.
- div_by_zero  output  1  result came from divisor == 0.

Behaviour:
- Reset (async, any state): state=IDLE, in_ready=1 once rst deasserts, out_valid=0, dout=0, remainder=0, div_by_zero=0, all internal registers cleared. Reset mid-operation discards the operation; no result is produced.
- States: IDLE, CALC, FIX, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready, latch magnitudes, sign bits, signed_mode and the divisor==0 flag; clear the iteration counter; go to CALC.
  - CALC: each cycle runs STEPS non-restoring steps on a (WIDTH+1)-bit signed partial remainder.
    - If the partial remainder >= 0, subtract the divisor; otherwise add it.
    - Each quotient bit = ~sign of the new partial remainder.
    - After N = 2*WIDTH/STEPS cycles, go to FIX.
  - FIX: if the partial remainder < 0, add the divisor once. Apply result signs (signed mode), register outputs, set out_valid=1, go to DONE.
  - DONE: out_valid=1, in_ready=0. On out_ready, next state is IDLE and out_valid drops at that edge.
- Latency and throughput:
  - Accept edge = edge 0; out_valid is high after edge N+1. WIDTH=4, STEPS=1 gives 9 cycles; STEPS=2 gives 5.
  - in_ready is high only in IDLE, so there is no same-cycle accept after a result handoff. Minimum initiation interval is N+3 cycles.
- Backpressure: while out_valid&&!out_ready, dout, remainder and div_by_zero are held stable. Input changes are ignored outside IDLE.
- Unsigned mode: plain unsigned division.
- Signed mode:
  - Operate on magnitudes. The dividend magnitude fits 2*WIDTH unsigned bits; the divisor magnitude fits WIDTH unsigned bits.
  - Quotient sign = sign(dividend) XOR sign(divisor); remainder sign = sign(dividend) (truncating division).
  - Quotient overflow (e.g. most-negative / -1) wraps modulo 2^(2*WIDTH) with no flag.
- Divide by zero:
  - Same state sequence and latency as a normal operation.
  - Outputs: dout = all ones, remainder = dividend[WIDTH-1:0] (raw, unsigned), div_by_zero = 1.
  - div_by_zero = 0 for every other result.
- Dividend 0: dout=0, remainder=0.

Decomposition:
- Package norestore_pkg:
  - state enum {IDLE, CALC, FIX, DONE};
  - function for the two's-complement magnitude;
  - localparam helpers for iteration count.
- Sub-module norestore_step: one combinational non-restoring step (partial remainder and divisor in; new partial remainder and quotient bit out). Instantiated STEPS times in a generate chain inside the CALC datapath.

Test Plan:
- WIDTH=4, STEPS=1, unsigned 200/13 (8'hC8, 4'hD) -> dout=8'h0F, remainder=4'h5, div_by_zero=0, out_valid high exactly after edge 9 from accept.
- Unsigned 255/1 -> dout=8'hFF, remainder=0; then 0/9 -> dout=0, remainder=0.
- Signed -100/7 (8'h9C, 4'h7) -> dout=8'hF2 (-14), remainder=4'hE (-2); signed 100/-8 (8'h64, 4'h8) -> dout=8'hF4 (-12), remainder=4'h4.
- 100/0 (8'h64, 4'h0) -> dout=8'hFF, remainder=4'h4, div_by_zero=1, latency 9 cycles.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0; raise out_ready -> IDLE, in_ready=1 next cycle, next operation accepted.
- Assert rst for 1 cycle during the 4th CALC cycle -> out_valid never rises for that operation, all outputs 0, in_ready=1. Rerun 200/13 with STEPS=2 -> correct result after edge 5.

Source files
------------

// File: rtl/norestore_pkg.sv
// Shared types and elaboration helpers for the non-restoring sequential divider.
package norestore_pkg;

  // Controller states: accept, iterate, correct/sign, hand off.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Widest divisor the magnitude helper below can carry (dividend is twice this).
  localparam int unsigned MAX_WIDTH = 32;

  // Number of CALC cycles needed to retire all 2*width quotient bits.
  function automatic int unsigned iter_count(input int unsigned width,
                                             input int unsigned steps);
    return (2 * width) / steps;
  endfunction

  // Counter width able to index iter_count() cycles (at least one bit).
  function automatic int unsigned count_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Two's-complement magnitude; callers truncate the result to their width.
  function automatic logic [63:0] twos_mag(input logic [63:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/norestore_step.sv
// One combinational non-restoring division step: shift in a dividend bit,
// then subtract or add the divisor depending on the sign of the old remainder.
module norestore_step #(
  parameter int WIDTH = 4
) (
  input  logic signed [WIDTH:0]   p_i,
  input  logic                    bit_i,
  input  logic        [WIDTH-1:0] d_i,
  output logic signed [WIDTH:0]   p_o,
  output logic                    q_o
);

  localparam int WP = WIDTH + 1;

  // One extra bit holds 2*P + bit before the divisor brings it back into range.
  logic signed [WIDTH+1:0] shifted;
  logic signed [WIDTH+1:0] d_ext;
  logic signed [WIDTH+1:0] sum;

  // Subtract when the old remainder is non-negative, add otherwise.
  always_comb begin
    shifted = {p_i, bit_i};
    d_ext   = {2'b00, d_i};
    sum     = p_i[WIDTH] ? (shifted + d_ext) : (shifted - d_ext);
    // The result always lies in [-d, d), so the top bit is redundant.
    p_o     = WP'(sum);
    q_o     = ~p_o[WIDTH];
  end

endmodule

// File: rtl/norestore_seq_divider.sv
// Iterative non-restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// STEPS iterations per clock, signed/unsigned per operation, valid/ready on
// both sides and divide-by-zero reporting.
module norestore_seq_divider
  import norestore_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int STEPS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 signed_mode,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   dout,
  output logic [WIDTH-1:0]     remainder,
  output logic                 div_by_zero
);

  localparam int DW = 2 * WIDTH;
  localparam int N  = int'(iter_count(WIDTH, STEPS));
  localparam int CW = int'(count_bits(N));

  if (WIDTH < 2 || WIDTH > int'(MAX_WIDTH)) begin : g_bad_width
    $error("norestore_seq_divider: WIDTH must be in 2..%0d", MAX_WIDTH);
  end
  if (STEPS < 1 || STEPS > DW) begin : g_bad_steps_range
    $error("norestore_seq_divider: STEPS must be in 1..2*WIDTH");
  end else if ((DW % STEPS) != 0) begin : g_bad_steps_div
    $error("norestore_seq_divider: STEPS must divide 2*WIDTH");
  end

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic signed [WIDTH:0]  p_q, p_d;         // partial remainder
  logic [DW-1:0]          q_q, q_d;         // dividend bits out, quotient bits in
  logic [WIDTH-1:0]       d_q, d_d;         // divisor magnitude
  logic                   q_neg_q, q_neg_d;
  logic                   r_neg_q, r_neg_d;
  logic                   dz_q, dz_d;
  logic [WIDTH-1:0]       raw_lo_q, raw_lo_d;
  logic [DW-1:0]          dout_q, dout_d;
  logic [WIDTH-1:0]       rem_q, rem_d;
  logic                   dbz_q, dbz_d;

  // Operand conditioning at accept time.
  logic                   dvd_neg, dvs_neg;
  logic [DW-1:0]          dvd_mag;
  logic [WIDTH-1:0]       dvs_mag;

  assign dvd_neg = signed_mode & dividend[DW-1];
  assign dvs_neg = signed_mode & divisor[WIDTH-1];
  assign dvd_mag = DW'(twos_mag(64'(dividend), dvd_neg));
  assign dvs_mag = WIDTH'(twos_mag(64'(divisor), dvs_neg));

  // Chain of STEPS combinational steps evaluated once per CALC cycle.
  logic signed [WIDTH:0]  p_chain [STEPS+1];
  logic [STEPS-1:0]       q_bits;
  logic [DW-1:0]          q_shifted;

  assign p_chain[0] = p_q;

  for (genvar s = 0; s < STEPS; s++) begin : g_step
    norestore_step #(.WIDTH(WIDTH)) u_step (
      .p_i   (p_chain[s]),
      .bit_i (q_q[DW-1-s]),
      .d_i   (d_q),
      .p_o   (p_chain[s+1]),
      .q_o   (q_bits[STEPS-1-s])
    );
  end

  assign q_shifted = (q_q << STEPS) | DW'(q_bits);

  // Final correction and sign application used in FIX.
  logic signed [WIDTH:0]  p_fix;
  logic [WIDTH-1:0]       rem_mag;
  logic [DW-1:0]          q_out;
  logic [WIDTH-1:0]       r_out;

  assign p_fix   = p_q[WIDTH] ? (p_q + $signed({1'b0, d_q})) : p_q;
  assign rem_mag = WIDTH'(p_fix);
  assign q_out   = q_neg_q ? (~q_q + DW'(1)) : q_q;
  assign r_out   = r_neg_q ? (~rem_mag + WIDTH'(1)) : rem_mag;

  // Next-state and datapath updates for every state.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    q_d      = q_q;
    d_d      = d_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    dz_d     = dz_q;
    raw_lo_d = raw_lo_q;
    dout_d   = dout_q;
    rem_d    = rem_q;
    dbz_d    = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          p_d      = '0;
          q_d      = dvd_mag;
          d_d      = dvs_mag;
          q_neg_d  = dvd_neg ^ dvs_neg;
          r_neg_d  = dvd_neg;
          dz_d     = (divisor == '0);
          raw_lo_d = dividend[WIDTH-1:0];
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        p_d   = p_chain[STEPS];
        q_d   = q_shifted;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (dz_q) begin
          dout_d = '1;
          rem_d  = raw_lo_q;
          dbz_d  = 1'b1;
        end else begin
          dout_d = q_out;
          rem_d  = r_out;
          dbz_d  = 1'b0;
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      p_q      <= '0;
      q_q      <= '0;
      d_q      <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      dz_q     <= 1'b0;
      raw_lo_q <= '0;
      dout_q   <= '0;
      rem_q    <= '0;
      dbz_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      q_q      <= q_d;
      d_q      <= d_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      dz_q     <= dz_d;
      raw_lo_q <= raw_lo_d;
      dout_q   <= dout_d;
      rem_q    <= rem_d;
      dbz_q    <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign dout        = dout_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
